// File: rtl/sdram_host_arbiter.sv
// sdram_host_arbiter
// Two-port round-robin front end for a single SDRAM controller host port.
// One request is latched at a time; the enable/busy/rd_rdy/rd_ack handshake
// is sequenced here and read data is routed back to the owning port.
module sdram_host_arbiter #(
  parameter int HADDR_WIDTH = 24,
  parameter int BUSY_WAIT   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // requester port 0
  input  logic                   req0_valid,
  input  logic                   req0_we,
  input  logic [HADDR_WIDTH-1:0] req0_addr,
  input  logic [15:0]            req0_wdata,
  output logic                   req0_ack,
  output logic [15:0]            rdata0,
  output logic                   rdata0_valid,
  // requester port 1
  input  logic                   req1_valid,
  input  logic                   req1_we,
  input  logic [HADDR_WIDTH-1:0] req1_addr,
  input  logic [15:0]            req1_wdata,
  output logic                   req1_ack,
  output logic [15:0]            rdata1,
  output logic                   rdata1_valid,
  // controller host port
  output logic [HADDR_WIDTH-1:0] haddr,
  output logic [15:0]            wr_data,
  output logic                   wr_enable,
  output logic                   rd_enable,
  input  logic                   busy,
  input  logic [15:0]            rd_data,
  input  logic                   rd_rdy,
  output logic                   rd_ack
);

  localparam int               CNT_W    = $clog2(BUSY_WAIT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RD_ACK    = 3'd4
  } state_t;

  state_t           state;
  logic             owner;       // port that owns the transaction in flight
  logic             op_we;       // 1 = write in flight, 0 = read in flight
  logic             last_grant;  // port granted most recently
  logic [CNT_W-1:0] busy_cnt;    // cycles spent waiting for busy to rise

  logic             any_req;
  logic             grant_port;

  // Round-robin pick: a lone requester wins, a tie goes to the port not granted last
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    any_req    = req0_valid | req1_valid;
    grant_port = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_port = ~last_grant;
    end else if (req1_valid) begin
      grant_port = 1'b1;
    end
  end

  // Arbitration/handshake FSM; every output is a register written only here
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: synchronous reset -- it is sampled on the clock like any other input.
      state        <= IDLE;
      owner        <= 1'b0;
      op_we        <= 1'b0;
      last_grant   <= 1'b1;
      busy_cnt     <= '0;
      haddr        <= '0;
      wr_data      <= '0;
      wr_enable    <= 1'b0;
      rd_enable    <= 1'b0;
      rd_ack       <= 1'b0;
      req0_ack     <= 1'b0;
      req1_ack     <= 1'b0;
      rdata0       <= '0;
      rdata1       <= '0;
      rdata0_valid <= 1'b0;
      rdata1_valid <= 1'b0;
    end else begin
      // NOTE: pulses default low each cycle and are raised only by the transition that needs them,
      // using non-blocking assignments so every register updates from pre-edge values.
      wr_enable    <= 1'b0;
      rd_enable    <= 1'b0;
      rd_ack       <= 1'b0;
      req0_ack     <= 1'b0;
      req1_ack     <= 1'b0;
      rdata0_valid <= 1'b0;
      rdata1_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (rd_rdy) begin
            // Stray read data with nothing outstanding: acknowledge and drop it,
            // and hold off any grant until the controller lowers rd_rdy.
            if (!rd_ack) begin
              rd_ack <= 1'b1;
            end
          end else if (!busy && any_req) begin
            owner      <= grant_port;
            last_grant <= grant_port;
            op_we      <= grant_port ? req1_we : req0_we;
            haddr      <= grant_port ? req1_addr : req0_addr;
            wr_data    <= grant_port ? req1_wdata : req0_wdata;
            wr_enable  <= grant_port ? req1_we : req0_we;
            rd_enable  <= grant_port ? ~req1_we : ~req0_we;
            req0_ack   <= ~grant_port;
            req1_ack   <= grant_port;
            state      <= ISSUE;
          end
        end

        ISSUE: begin
          busy_cnt <= '0;
          state    <= WAIT_BUSY;
        end

        WAIT_BUSY: begin
          // A controller that never raises busy is assumed to have taken the command.
          if (busy || (busy_cnt == CNT_LAST)) begin
            state <= WAIT_DONE;
          end else if (busy_cnt != CNT_MAX) begin
            busy_cnt <= busy_cnt + 1'b1;
          end
        end

        WAIT_DONE: begin
          if (op_we) begin
            if (!busy) begin
              state <= IDLE;
            end
          end else if (rd_rdy) begin
            rd_ack <= 1'b1;
            if (owner) begin
              rdata1       <= rd_data;
              rdata1_valid <= 1'b1;
            end else begin
              rdata0       <= rd_data;
              rdata0_valid <= 1'b1;
            end
            state <= RD_ACK;
          end
        end

        RD_ACK: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sdram_host_arbiter.md
# sdram_host_arbiter

Two-port round-robin arbiter that shares the single SDRAM controller host port (haddr, wr_data, wr_enable, rd_enable, busy, rd_data, rd_rdy, rd_ack) between two requesters, e.g. the board button/DIP interface and a pattern/self-test engine. It latches one request at a time, sequences the enable/busy/rd_rdy/rd_ack handshake with the controller, and routes read data back to the owning port. It sits between the requesters and the SDRAM controller, one instance per controller.

## Interface
- HADDR_WIDTH, 24, host address width; matches the controller.
- BUSY_WAIT, 4, max cycles after an issue to wait for busy to rise before treating the command as already accepted.
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req0_valid, req1_valid  in  1  request pending; held until the matching ack
- req0_we, req1_we  in  1  1 = write, 0 = read; sampled with valid
- req0_addr, req1_addr  in  HADDR_WIDTH  request address
- req0_wdata, req1_wdata  in  16  write data
- req0_ack, req1_ack  out  1  one-cycle pulse: request accepted; requester may change its inputs next cycle
- rdata0, rdata1  out  16  read data for the port; holds its value until the next read for that port
- rdata0_valid, rdata1_valid  out  1  one-cycle pulse: rdataN updated
- haddr  out  HADDR_WIDTH  address to the controller
- wr_data  out  16  write data to the controller
- wr_enable, rd_enable  out  1  one-cycle command strobes to the controller
- busy  in  1  controller busy
- rd_data  in  16  controller read data
- rd_rdy  in  1  controller read data available
- rd_ack  out  1  one-cycle read-data acknowledge to the controller

## Operation
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RD_ACK.
- IDLE: when busy=0, rd_rdy=0 and at least one reqN_valid is high, pick the owner:
  - If only one port is valid, that port wins.
  - If both are valid, the port not granted last wins.
  - last_grant resets to 1, so port 0 wins the first tie.
  - On a grant, latch we/addr/wdata into haddr/wr_data and an owner/op register, update last_grant, and go to ISSUE.
- ISSUE (exactly one cycle):
  - wr_enable=1 for a write, rd_enable=1 for a read.
  - reqN_ack=1 for the owner.
  - Go to WAIT_BUSY with the timeout counter cleared.
- WAIT_BUSY:
  - If busy=1, go to WAIT_DONE.
  - Otherwise the counter increments; when it reaches BUSY_WAIT-1, go to WAIT_DONE anyway.
  - The counter is a clog2(BUSY_WAIT)+1-bit saturating counter.
- WAIT_DONE:
  - Write: exit to IDLE when busy=0.
  - Read: exit to RD_ACK when rd_rdy=1, regardless of busy. The wait is unbounded; reset is the only recovery.
- RD_ACK (one cycle):
  - rd_ack=1.
  - rdataOwner<=rd_data and rdataOwner_valid=1 (registered, same cycle as rd_ack).
  - Go to IDLE.
- rd_rdy=1 while in IDLE with no read outstanding: pulse rd_ack for one cycle, discard the data, and issue no grant that cycle.
- haddr and wr_data hold their last latched value between transactions.
- Reset mid-operation:
  - FSM returns to IDLE and all strobes, acks and valids drop.
  - rdata0/1, haddr, wr_data clear to 0; last_grant is set to 1.
  - A request that was not acked stays pending at its requester and is re-arbitrated after reset.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Grant latency: valid seen in IDLE at cycle T (busy=0, rd_rdy=0) → enable and ack at T+1.
- Write turnaround, busy high at T+2 and low at T+k: back in IDLE at T+k+1; the next issue is at T+k+2 at the earliest.
- Read: rd_rdy first high at cycle R in WAIT_DONE → rd_ack, rdataN and rdataN_valid at R+1.
- Acks:
  - At most one reqN_ack per transaction.
  - req0_ack and req1_ack are never high together.
  - Never more than one command strobe per transaction.
- Simultaneous valid on both ports at every IDLE: grants strictly alternate 0,1,0,1.
- A valid that rises while another transaction is in flight waits for IDLE; it is never dropped.

## Test plan
- Single write, port 0, addr=0x00A5A5, wdata=0x5AA5, controller busy high for 6 cycles → ack0 and wr_enable at T+1, haddr=0x00A5A5, wr_data=0x5AA5, IDLE after busy falls, no rd_ack.
- Read, port 1, addr=0x000123, controller returns rd_data=0xBEEF with rd_rdy 10 cycles later → rd_enable once, ack1 once, rd_ack and rdata1_valid one cycle after rd_rdy, rdata1=0xBEEF, rdata0 unchanged at 0.
- Both ports hold valid for 8 transactions → grant order 0,1,0,1,0,1,0,1; no cycle with both acks high.
- Controller never raises busy after a write → WAIT_BUSY exits after BUSY_WAIT=4 cycles, IDLE is reached, and the next request is served.
- Stray rd_rdy while IDLE → exactly one rd_ack pulse, no rdataN_valid, and a pending request is granted only after rd_rdy drops.
- rst_n low for one cycle during WAIT_DONE of a port-0 read → all outputs 0 next cycle, FSM in IDLE, and the later rd_rdy is discarded as stray.
